// File: rtl/review2015_pkg.sv
// Shared constants for the 2015 review timer: delay/prescaler sizing and the
// one-hot state indices of the upstream timer FSM.
package review2015_pkg;

    localparam int DELAY_W     = 4;
    localparam int UNIT_CYCLES = 1000;
    localparam int PRE_W       = 10;

    // Bit positions of the one-hot FSM state vector that drives this stage.
    typedef enum logic [3:0] {
        S     = 4'd0,
        S1    = 4'd1,
        S11   = 4'd2,
        S110  = 4'd3,
        B0    = 4'd4,
        B1    = 4'd5,
        B2    = 4'd6,
        B3    = 4'd7,
        COUNT = 4'd8,
        WAIT  = 4'd9
    } state_idx_t;

endpackage

// File: rtl/review2015_delay_timer_if.sv
// FSM <-> delay timer signal bundle. Defining REVIEW2015_PAR_LOAD_EN adds the
// parallel load path (load, delay_in).
interface review2015_delay_timer_if;
    import review2015_pkg::*;

    logic               data;
    logic               shift_ena;
    logic               counting;
    logic               done_counting;
    logic [DELAY_W-1:0] count;
`ifdef REVIEW2015_PAR_LOAD_EN
    logic               load;
    logic [DELAY_W-1:0] delay_in;

    modport master (output data, shift_ena, counting, load, delay_in,
                    input  done_counting, count);
    modport slave  (input  data, shift_ena, counting, load, delay_in,
                    output done_counting, count);
`else
    modport master (output data, shift_ena, counting,
                    input  done_counting, count);
    modport slave  (input  data, shift_ena, counting,
                    output done_counting, count);
`endif

endinterface

// File: rtl/review2015_unit_prescaler.sv
// Mod-UNIT_CYCLES counter; tick marks the last cycle of each delay unit while
// running. Any cycle without run restarts the unit from zero.
module review2015_unit_prescaler #(
    parameter int UNIT_CYCLES = 1000,
    parameter int PRE_W       = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(UNIT_CYCLES - 1);

    logic [PRE_W-1:0] cnt;

    assign tick = run & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/review2015_delay_timer.sv
// Delay timer datapath: serial delay capture and (delay+1)*UNIT_CYCLES timeout.
// Optional parallel load enabled by REVIEW2015_PAR_LOAD_EN.
module review2015_delay_timer
    import review2015_pkg::*;
(
    input  logic clk,
    input  logic reset,
    review2015_delay_timer_if.slave bus
);

    localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);

    logic [DELAY_W-1:0] delay;
    logic               clr;
    logic               run;
    logic               tick;

`ifdef REVIEW2015_PAR_LOAD_EN
    assign clr = bus.load | bus.shift_ena;
`else
    assign clr = bus.shift_ena;
`endif
    // Loading or shifting always beats counting, so the unit cannot run then.
    assign run = bus.counting & ~clr;

    review2015_unit_prescaler #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .PRE_W       (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            delay <= '0;
`ifdef REVIEW2015_PAR_LOAD_EN
        end else if (bus.load) begin
            delay <= bus.delay_in;
`endif
        end else if (bus.shift_ena) begin
            delay <= {delay[DELAY_W-2:0], bus.data};
        end else if (tick && (delay != '0)) begin
            delay <= delay - ONE;
        end
    end

    // At delay 0 the terminal unit tick is the timeout itself; delay holds 0.
    assign bus.done_counting = tick & (delay == '0);
    assign bus.count         = delay;

endmodule

// File: tb/tb_review2015_delay_timer.sv
// Self-checking bench for review2015_delay_timer; expected pulses and count
// values are queued before each counting run and consumed as cycles elapse.
module tb_review2015_delay_timer;
    import review2015_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    review2015_delay_timer_if bus ();

    review2015_delay_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                 cyc;
        logic [DELAY_W-1:0] cnt;
    } cnt_exp_t;

    int       tests_run = 0;
    int       fails     = 0;
    int       pulse_q[$];
    cnt_exp_t cnt_q[$];

    // Drive one cycle of inputs, then sample the outputs before the next edge.
    task automatic cyc(input logic sh, input logic d, input logic cn, input logic rs);
        @(negedge clk);
        bus.shift_ena = sh;
        bus.data      = d;
        bus.counting  = cn;
        reset         = rs;
`ifdef REVIEW2015_PAR_LOAD_EN
        bus.load      = 1'b0;
        bus.delay_in  = '0;
`endif
        #1;
    endtask

    task automatic shift4(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) cyc(1'b1, v[i], 1'b0, 1'b0);
    endtask

    task automatic push_cnt(input int c, input logic [DELAY_W-1:0] v);
        cnt_exp_t e;
        e.cyc = c;
        e.cnt = v;
        cnt_q.push_back(e);
    endtask

    // Counting cycles are numbered from 1 within each run.
    task automatic run_count(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            logic exp_done;
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            exp_done = (pulse_q.size() > 0) && (pulse_q[0] == i);
            tests_run++;
            if (bus.done_counting !== exp_done) begin
                fails++;
                $display("FAIL %s done_counting@%0d: got %b expected %b", tag, i, bus.done_counting, exp_done);
            end
            if (exp_done) void'(pulse_q.pop_front());
            if ((cnt_q.size() > 0) && (cnt_q[0].cyc == i)) begin
                cnt_exp_t e;
                e = cnt_q.pop_front();
                tests_run++;
                if (bus.count !== e.cnt) begin
                    fails++;
                    $display("FAIL %s count@%0d: got %0d expected %0d", tag, i, bus.count, e.cnt);
                end
            end
        end
        while (pulse_q.size() > 0) begin
            tests_run++;
            fails++;
            $display("FAIL %s pulse missing, expected at cycle %0d", tag, pulse_q.pop_front());
        end
        while (cnt_q.size() > 0) begin
            cnt_exp_t e;
            e = cnt_q.pop_front();
            tests_run++;
            fails++;
            $display("FAIL %s count@%0d: never sampled, expected %0d", tag, e.cyc, e.cnt);
        end
    endtask

    task automatic check_idle(input string tag, input logic [DELAY_W-1:0] exp_cnt);
        tests_run++;
        if (bus.count !== exp_cnt) begin
            fails++;
            $display("FAIL %s count: got %0d expected %0d", tag, bus.count, exp_cnt);
        end
        tests_run++;
        if (bus.done_counting !== 1'b0) begin
            fails++;
            $display("FAIL %s done_counting: got %b expected 0", tag, bus.done_counting);
        end
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_idle("reset", 4'd0);
    endtask

    task automatic test_delay11();
        shift4(4'b1011);
        push_cnt(1, 4'd11);
        push_cnt(1000, 4'd11);
        push_cnt(1001, 4'd10);
        push_cnt(12000, 4'd0);
        pulse_q.push_back(12000);
        run_count(12000, "delay11");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_delay0();
        shift4(4'b0000);
        push_cnt(1, 4'd0);
        pulse_q.push_back(1000);
        run_count(1001, "delay0");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gap();
        shift4(4'b0010);
        push_cnt(500, 4'd2);
        run_count(500, "gap_pre");
        for (int g = 0; g < 3; g++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check_idle("gap_idle", 4'd2);
        end
        push_cnt(1, 4'd2);
        pulse_q.push_back(3000);
        run_count(3000, "gap_resume");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        shift4(4'b0101);
        push_cnt(4320, 4'd1);
        run_count(4320, "midrst_pre");
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_idle("midrst_after", 4'd0);
        // A cleared prescaler puts the delay-0 timeout exactly one unit out.
        pulse_q.push_back(1000);
        run_count(1000, "midrst_post");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_shift_and_count();
        shift4(4'b0000);
        run_count(999, "both_pre");
        $display("[TB] note: shift_ena and counting driven together (FSM protocol violation)");
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (bus.done_counting !== 1'b0) begin
            fails++;
            $display("FAIL both done_counting: got %b expected 0", bus.done_counting);
        end
        push_cnt(1, 4'd1);
        pulse_q.push_back(2000);
        run_count(2000, "both_post");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef REVIEW2015_PAR_LOAD_EN
    task automatic test_par_load();
        shift4(4'b0000);
        @(negedge clk);
        bus.shift_ena = 1'b1;
        bus.data      = 1'b0;
        bus.counting  = 1'b0;
        bus.load      = 1'b1;
        bus.delay_in  = 4'd15;
        reset         = 1'b0;
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_idle("load", 4'd15);
        push_cnt(16000, 4'd0);
        pulse_q.push_back(16000);
        run_count(16000, "load_run");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.data      = 1'b0;
        bus.shift_ena = 1'b0;
        bus.counting  = 1'b0;
`ifdef REVIEW2015_PAR_LOAD_EN
        bus.load      = 1'b0;
        bus.delay_in  = '0;
`endif
        test_reset();
        test_delay11();
        test_delay0();
        test_gap();
        test_mid_reset();
        test_shift_and_count();
`ifdef REVIEW2015_PAR_LOAD_EN
        test_par_load();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
